// File: rtl/finite_mod_accum.sv
// Running sum of 5-bit residue words mod MOD, buffered in a DEPTH-entry FIFO on a valid/ready stream.
// Define FINITE_RANGE_CHECK_EN to add the saturating out-of-range word counter err_cnt.
module finite_mod_accum #(
  parameter int MOD   = 20,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] in_data,
  input  logic       in_cont,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready
`ifdef FINITE_RANGE_CHECK_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [4:0] MOD5 = 5'(MOD);
  localparam logic [5:0] MOD6 = 6'(MOD);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [4:0] sum;
    logic       last;
  } entry_t;

  state_t                 state;
  logic [4:0]             acc;
  entry_t [DEPTH-1:0]     mem;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  logic [4:0] red, acc_nxt;
  logic [5:0] sum6;
  logic       full, empty, accept, pop, last_pop;
  entry_t     head;

  // A modulus of at least 16 lets one conditional subtraction fully reduce any 5-bit value
  assign red     = (in_data >= MOD5) ? in_data - MOD5 : in_data;
  assign sum6    = {1'b0, acc} + {1'b0, red};
  assign acc_nxt = (sum6 >= MOD6) ? 5'(sum6 - MOD6) : sum6[4:0];

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = rst & (state != DRAIN) & ~full;
  assign accept   = in_valid & in_ready;
  assign head     = mem[rd_ptr];
  assign out_valid = ~empty;
  assign out_data  = head.sum;
  assign out_last  = head.last;
  assign pop       = out_valid & out_ready;
  assign last_pop  = pop & head.last & (state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= '{sum: acc_nxt, last: ~in_cont};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // DRAIN blocks input, so acc cannot be touched until the tagged word has left
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      if (accept)        acc <= acc_nxt;
      else if (last_pop) acc <= '0;
      case (state)
        IDLE:    if (accept) state <= in_cont ? RUN : DRAIN;
        RUN:     if (accept && !in_cont) state <= DRAIN;
        DRAIN:   if (last_pop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FINITE_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_cnt <= '0;
    else if (accept && (in_data >= MOD5) && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_finite_mod_accum.sv
// Scoreboard bench for finite_mod_accum: driver pushes model sums on accept, monitor checks the FIFO head.
module tb_finite_mod_accum;
  localparam int MOD   = 20;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] in_data = '0;
  logic       in_cont = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef FINITE_RANGE_CHECK_EN
  logic [7:0] err_cnt;
  int         err_m = 0;
`endif

  always #5 clk = ~clk;

  finite_mod_accum #(.MOD(MOD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_cont(in_cont), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FINITE_RANGE_CHECK_EN
    , .err_cnt(err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sum;
    bit last;
  } exp_t;
  exp_t q[$];
  int   acc_m = 0;
  bit   rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum of reduced words mod MOD, restarting after a word with cont=0
  function automatic void model_accept(input int d, input bit c);
    int r;
    r = d % MOD;
    acc_m = (acc_m + r) % MOD;
    q.push_back('{sum: acc_m, last: !c});
    if (!c) acc_m = 0;
`ifdef FINITE_RANGE_CHECK_EN
    if (d >= MOD && err_m < 255) err_m++;
`endif
  endfunction

  task automatic cycle(input bit v, input int d, input bit c, input bit rdy, output bit acc);
    @(posedge clk); #1;
    in_valid  = v;
    in_data   = 5'(d);
    in_cont   = c;
    out_ready = rnd_rdy ? ($urandom_range(3) != 0) : rdy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) model_accept(d, c);
  endtask

  task automatic send(input int d, input bit c, input bit rdy);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 200) begin
      cycle(1'b1, d, c, rdy, a);
      n++;
    end
    if (!a) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %0d never accepted", d);
    end
  endtask

  task automatic drain_all();
    bit a;
    int n = 0;
    do begin
      cycle(1'b0, 0, 1'b0, 1'b1, a);
      n++;
    end while ((q.size() != 0 || out_valid) && n < 300);
    if (q.size() != 0 || out_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d expected entries left, out_valid=%0b", q.size(), out_valid);
    end
  endtask

  // Monitor: the head must match the oldest expected entry whenever valid (also covers hold under stall)
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got data %0d last %0b, expected nothing", out_data, out_last);
      end else begin
        chk("out_data", 32'(out_data), 32'(q[0].sum));
        chk("out_last", 32'(out_last), 32'(q[0].last));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int acc_cnt;

    // Reset state
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
`ifdef FINITE_RANGE_CHECK_EN
    chk("rst_err_cnt", 32'(err_cnt), 0);
`endif
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 1);

    // Basic sequence: 7, 13, 12(last)
    send(7, 1'b1, 1'b1);
    send(6, 1'b1, 1'b1);
    send(19, 1'b0, 1'b1);
    drain_all();

    // Out-of-range single word
    send(25, 1'b0, 1'b1);
    drain_all();
`ifdef FINITE_RANGE_CHECK_EN
    chk("err_cnt_oor", 32'(err_cnt), 1);
`endif

    // Backpressure: 4 of 5 offered words fit
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1 + i, 1'b1, 1'b0, a);
      if (a) acc_cnt++;
    end
    chk("bp_accepted", 32'(acc_cnt), 4);
    chk("bp_in_ready_full", 32'(in_ready), 0);
    send(5, 1'b1, 1'b1);
    send(0, 1'b0, 1'b1);
    drain_all();

    // DRAIN lockout
    send(3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 0, 1'b0, 1'b0, a);
      chk("drain_in_ready", 32'(in_ready), 0);
    end
    cycle(1'b0, 0, 1'b0, 1'b1, a);
    cycle(1'b0, 0, 1'b0, 1'b0, a);
    chk("post_drain_in_ready", 32'(in_ready), 1);
    send(4, 1'b1, 1'b1);
    send(0, 1'b0, 1'b1);
    drain_all();

    // Reset mid-sequence
    send(10, 1'b1, 1'b0);
    send(15, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, a);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    q.delete();
    acc_m = 0;
`ifdef FINITE_RANGE_CHECK_EN
    err_m = 0;
    chk("midrst_err_cnt", 32'(err_cnt), 0);
`endif
    #2 rst = 1'b1;
    send(2, 1'b0, 1'b1);
    drain_all();

    // Saturation run: each sum advances by 11 mod 20
    for (int i = 0; i < 300; i++) send(31, 1'b1, 1'b1);
    send(0, 1'b0, 1'b1);
    drain_all();
`ifdef FINITE_RANGE_CHECK_EN
    chk("err_cnt_sat", 32'(err_cnt), 255);
`endif

    // Random words with random sink stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++)
      send(int'($urandom_range(31)), ($urandom_range(4) != 0), 1'b1);
    send(1, 1'b0, 1'b1);
    rnd_rdy = 1'b0;
    drain_all();
`ifdef FINITE_RANGE_CHECK_EN
    chk("err_cnt_final", 32'(err_cnt), 32'(err_m));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
